// File: rtl/qspi_arb.sv
// qspi_arb: arbiter/sequencer sharing the qspi line-transfer engine between
// icache fill, dcache write-back/fill and (optionally) io register writes.
// The grant is held for the whole transfer. Every request field is registered,
// and a one-cycle done pulse goes back to the owner.
// Optional feature macro: IO_ARB_EN adds the io register-write path (IO_WR state).
module qspi_arb #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4,
    localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fault,
    input  logic          i_pull,
    input  logic [TW-1:0] i_tag,
    input  logic          d_push,
    input  logic          d_pull,
    input  logic [TW-1:0] d_tag,
    input  logic          io_req,
    input  logic [3:0]    io_addr,
    input  logic [7:0]    io_data,
    input  logic          q_done,
    output logic          q_req,
    output logic          q_i_d,
    output logic          q_write,
    output logic          q_mem,
    output logic [TW-1:0] q_paddr,
    output logic          q_reg_write,
    output logic [3:0]    q_reg_addr,
    output logic [7:0]    q_reg_data,
    output logic          i_done,
    output logic          d_done,
    output logic          io_ack,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, I_FILL, D_PUSH, D_PULL
`ifdef IO_ARB_EN
        , IO_WR
`endif
    } state_t;

    // Line request presented to qspi by the winning side
    typedef struct packed {
        logic          i_d;
        logic          write;
        logic [TW-1:0] paddr;
    } qreq_t;

    state_t state;
    logic   last_d;   // 1 = D was the last cache side granted
    logic   d_want;
    logic   pick_i;
    logic   pick_d;
    qreq_t  win;

    // RAM target when the top seven line-address bits are all ones
    function automatic logic is_mem(input logic [TW-1:0] tag);
        return &tag[TW-1:TW-7];
    endfunction

    // I vs D round-robin: on a tie the side not served last wins
    always_comb begin
        d_want    = d_push | d_pull;
        pick_i    = i_pull & (~d_want | last_d);
        pick_d    = d_want & ~pick_i;
        win.i_d   = pick_i;
        win.write = pick_d & d_push;
        win.paddr = pick_i ? i_tag : d_tag;
    end

    // Grant/sequence FSM; all qspi fields and done pulses are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            q_req   <= 1'b0;
            q_i_d   <= 1'b0;
            q_write <= 1'b0;
            q_mem   <= 1'b0;
            q_paddr <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            busy    <= 1'b0;
`ifdef IO_ARB_EN
            q_reg_write <= 1'b0;
            q_reg_addr  <= '0;
            q_reg_data  <= '0;
            io_ack      <= 1'b0;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
`ifdef IO_ARB_EN
            q_reg_write <= 1'b0;
            io_ack      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!fault) begin
`ifdef IO_ARB_EN
                        if (io_req) begin
                            state       <= IO_WR;
                            busy        <= 1'b1;
                            q_reg_write <= 1'b1;
                            io_ack      <= 1'b1;
                            q_reg_addr  <= io_addr;
                            q_reg_data  <= io_data;
                        end else
`endif
                        if (pick_i || pick_d) begin
                            state   <= pick_i ? I_FILL : (d_push ? D_PUSH : D_PULL);
                            last_d  <= pick_d;
                            busy    <= 1'b1;
                            q_req   <= 1'b1;
                            q_i_d   <= win.i_d;
                            q_write <= win.write;
                            q_paddr <= win.paddr;
                            q_mem   <= is_mem(win.paddr);
                        end
                    end
                end
                I_FILL, D_PULL: begin
                    if (q_done) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        q_req  <= 1'b0;
                        i_done <= (state == I_FILL);
                        d_done <= (state == D_PULL);
                    end
                end
                D_PUSH: begin
                    if (q_done) begin
                        d_done  <= 1'b1;
                        q_write <= 1'b0;
                        // Chain straight into the fill so no I grant can slip in
                        if (d_pull) begin
                            state   <= D_PULL;
                            q_paddr <= d_tag;
                            q_mem   <= is_mem(d_tag);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            q_req <= 1'b0;
                        end
                    end
                end
`ifdef IO_ARB_EN
                IO_WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef IO_ARB_EN
    logic unused_io;
    assign unused_io   = ^{io_req, io_addr, io_data};
    assign q_reg_write = 1'b0;
    assign q_reg_addr  = '0;
    assign q_reg_data  = '0;
    assign io_ack      = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: directed scenarios plus randomized traffic checked against a
// transaction-level reference model of the arbiter.
module tb_qspi_arb;
    localparam int TW = 20;
`ifdef IO_ARB_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b0, fault = 1'b0;
    logic          i_pull = 1'b0, d_push = 1'b0, d_pull = 1'b0, io_req = 1'b0, q_done = 1'b0;
    logic [TW-1:0] i_tag = '0, d_tag = '0;
    logic [3:0]    io_addr = '0;
    logic [7:0]    io_data = '0;
    logic          q_req, q_i_d, q_write, q_mem, q_reg_write, i_done, d_done, io_ack, busy;
    logic [TW-1:0] q_paddr;
    logic [3:0]    q_reg_addr;
    logic [7:0]    q_reg_data;

    int n_chk = 0;
    int n_err = 0;
    int dd    = 0;

    always #5 clk = ~clk;

    qspi_arb #(.PA(22), .LINE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .fault(fault),
        .i_pull(i_pull), .i_tag(i_tag),
        .d_push(d_push), .d_pull(d_pull), .d_tag(d_tag),
        .io_req(io_req), .io_addr(io_addr), .io_data(io_data),
        .q_done(q_done), .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write),
        .q_mem(q_mem), .q_paddr(q_paddr), .q_reg_write(q_reg_write),
        .q_reg_addr(q_reg_addr), .q_reg_data(q_reg_data),
        .i_done(i_done), .d_done(d_done), .io_ack(io_ack), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the transaction currently owning qspi
    typedef enum logic [2:0] {K_NONE, K_I, K_PUSH, K_PULL, K_IO} kind_t;
    typedef struct {
        kind_t         kind;
        logic [TW-1:0] addr;
        logic [3:0]    ra;
        logic [7:0]    rd;
    } txn_t;

    txn_t cur;
    bit   m_last_d;
    bit   m_idone, m_ddone;

    task automatic model_step();
        bit wi, wd, take_d;
        m_idone = 0;
        m_ddone = 0;
        case (cur.kind)
            K_NONE: if (!fault) begin
                wi = i_pull;
                wd = d_push | d_pull;
                if (IO_EN && io_req) begin
                    cur.kind = K_IO;
                    cur.ra   = io_addr;
                    cur.rd   = io_data;
                end else if (wi || wd) begin
                    take_d   = wd && (!wi || !m_last_d);
                    m_last_d = take_d;
                    cur.kind = !take_d ? K_I : (d_push ? K_PUSH : K_PULL);
                    cur.addr = take_d ? d_tag : i_tag;
                end
            end
            K_IO: cur.kind = K_NONE;
            default: if (q_done) begin
                if (cur.kind == K_I) m_idone = 1;
                else m_ddone = 1;
                if (cur.kind == K_PUSH && d_pull) begin
                    cur.kind = K_PULL;
                    cur.addr = d_tag;
                end else begin
                    cur.kind = K_NONE;
                end
            end
        endcase
    endtask

    task automatic compare();
        logic xfer, io;
        xfer = cur.kind inside {K_I, K_PUSH, K_PULL};
        io   = (cur.kind == K_IO);
        chk("rnd_ctl", 32'({q_req, busy, i_done, d_done, q_reg_write, io_ack}),
            32'({xfer, cur.kind != K_NONE, m_idone, m_ddone, io, io}));
        if (xfer)
            chk("rnd_req", 32'({q_i_d, q_write, q_mem, q_paddr}),
                32'({cur.kind == K_I, cur.kind == K_PUSH, &cur.addr[19:13], cur.addr}));
        if (io)
            chk("rnd_reg", 32'({q_reg_addr, q_reg_data}), 32'({cur.ra, cur.rd}));
    endtask

    initial begin
        logic exp_i;
        // Reset state
        tick();
        chk("rst_ctl", 32'({q_req, q_i_d, q_write, q_mem, q_reg_write, i_done, d_done, io_ack, busy}), 32'd0);
        chk("rst_addr", 32'(q_paddr), 32'd0);
        chk("rst_reg", 32'({q_reg_addr, q_reg_data}), 32'd0);
        reset = 1'b1;
        tick();

        // Tie fairness: D first after reset, then alternate
        i_pull = 1; d_pull = 1; i_tag = 20'h11111; d_tag = 20'h22222;
        for (int k = 0; k < 4; k++) begin
            exp_i = 1'(k & 1);
            tick();
            chk("tie_grant", 32'({q_req, q_i_d}), 32'({1'b1, exp_i}));
            chk("tie_addr", 32'(q_paddr), exp_i ? 32'h11111 : 32'h22222);
            q_done = 1;
            tick();
            chk("tie_done", 32'({i_done, d_done, q_req}), 32'({exp_i, ~exp_i, 1'b0}));
            q_done = 0;
        end
        i_pull = 0; d_pull = 0;
        tick();

        // Icache fill
        i_pull = 1; i_tag = 20'hFFE01;
        tick();
        chk("fill_ctl", 32'({q_req, q_i_d, q_mem, q_write, busy}), 32'b11101);
        chk("fill_addr", 32'(q_paddr), 32'hFFE01);
        i_pull = 0;
        tick();
        chk("fill_hold", 32'({q_req, i_done}), 32'b10);
        q_done = 1;
        tick();
        chk("fill_done", 32'({i_done, q_req, busy}), 32'b100);
        q_done = 0;
        tick();
        chk("fill_pulse", 32'(i_done), 32'd0);

        // Write-back chain, with an I request arriving mid-chain
        d_push = 1; d_pull = 1; d_tag = 20'h00123;
        tick();
        chk("wb_push", 32'({q_req, q_write, q_i_d}), 32'b110);
        chk("wb_addr1", 32'(q_paddr), 32'h00123);
        dd = 0;
        d_push = 0; d_tag = 20'h00456; i_pull = 1; i_tag = 20'hFFE01; q_done = 1;
        tick();
        dd += int'(d_done);
        chk("wb_chain", 32'({q_req, q_write, q_i_d, d_done, busy}), 32'b10011);
        chk("wb_addr2", 32'(q_paddr), 32'h00456);
        q_done = 0; d_pull = 0;
        tick();
        dd += int'(d_done);
        chk("wb_pull", 32'({q_req, q_i_d, d_done}), 32'b100);
        q_done = 1;
        tick();
        dd += int'(d_done);
        chk("wb_end", 32'({q_req, busy}), 32'd0);
        q_done = 0;
        tick();
        dd += int'(d_done);
        chk("wb_cnt", 32'(dd), 32'd2);
        chk("wb_then_i", 32'({q_req, q_i_d}), 32'b11);
        i_pull = 0; q_done = 1;
        tick();
        q_done = 0;
        tick();

        // Fault gating, and fault mid-transfer does not abort
        fault = 1; i_pull = 1; i_tag = 20'h00ABC;
        tick();
        chk("flt_block1", 32'({q_req, busy}), 32'd0);
        tick();
        chk("flt_block2", 32'({q_req, busy}), 32'd0);
        fault = 0;
        tick();
        chk("flt_grant", 32'({q_req, q_mem, q_i_d}), 32'b101);
        fault = 1; q_done = 1;
        tick();
        chk("flt_nabort", 32'({i_done, q_req}), 32'b10);
        fault = 0; q_done = 0; i_pull = 0;
        tick();

`ifdef IO_ARB_EN
        // IO priority over a pending I request
        io_req = 1; io_addr = 4'h3; io_data = 8'hA5; i_pull = 1; i_tag = 20'hFFE01;
        tick();
        chk("io_strobe", 32'({q_reg_write, io_ack, q_req, busy}), 32'b1101);
        chk("io_reg", 32'({q_reg_addr, q_reg_data}), 32'h3A5);
        io_req = 0;
        tick();
        chk("io_gap", 32'({q_reg_write, io_ack, q_req, busy}), 32'd0);
        tick();
        chk("io_then_i", 32'({q_req, q_i_d}), 32'b11);
        i_pull = 0; q_done = 1;
        tick();
        q_done = 0;
        tick();
`else
        // Without the io path, io requests are ignored
        io_req = 1; io_addr = 4'h3; io_data = 8'hA5;
        tick();
        chk("io_off1", 32'({q_reg_write, io_ack, busy, q_req}), 32'd0);
        tick();
        chk("io_off2", 32'({q_reg_write, io_ack, busy, q_req, q_reg_addr, q_reg_data}), 32'd0);
        io_req = 0;
        tick();
`endif

        // Reset mid-fill: outputs drop asynchronously, no done afterwards
        i_pull = 1; i_tag = 20'hFFE01;
        tick();
        chk("rmf_req", 32'(q_req), 32'd1);
        i_pull = 0;
        #2 reset = 0;
        #1;
        chk("rmf_async", 32'({q_req, busy, q_i_d, q_mem}), 32'd0);
        chk("rmf_addr", 32'(q_paddr), 32'd0);
        tick();
        reset = 1; q_done = 1;
        tick();
        chk("rmf_nodone", 32'({i_done, q_req, busy}), 32'd0);
        q_done = 0;

        // Randomized traffic against the reference model
        reset = 0;
        tick();
        reset = 1;
        cur.kind = K_NONE; cur.addr = '0; cur.ra = '0; cur.rd = '0;
        m_last_d = 0; m_idone = 0; m_ddone = 0;
        for (int n = 0; n < 3000; n++) begin
            i_pull  = ($urandom_range(0, 1) == 1);
            d_push  = ($urandom_range(0, 3) == 0);
            d_pull  = ($urandom_range(0, 1) == 1);
            io_req  = ($urandom_range(0, 7) == 0);
            fault   = ($urandom_range(0, 7) == 0);
            q_done  = ($urandom_range(0, 2) == 0);
            i_tag   = 20'($urandom());
            d_tag   = 20'($urandom());
            if ($urandom_range(0, 1) == 1) i_tag[19:13] = '1;
            if ($urandom_range(0, 1) == 1) d_tag[19:13] = '1;
            io_addr = 4'($urandom());
            io_data = 8'($urandom());
            tick();
            model_step();
            compare();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
